// File: rtl/multi_cycle_adder_pkg.sv
// Package for the multi-cycle adder: re-exports the shared header
// definitions as typed constants.
package multi_cycle_adder_pkg;

`include "adder_ctrl_defs.vh"

    localparam logic [1:0] ST_IDLE = `ADDER_ST_IDLE;
    localparam logic [1:0] ST_ADD  = `ADDER_ST_ADD;
    localparam logic [1:0] ST_DONE = `ADDER_ST_DONE;

    localparam int DEFAULT_WIDTH = `ADDER_DEFAULT_WIDTH;

endpackage

// File: rtl/adder_ctrl_defs.vh
// Shared control definitions for the multi-cycle adder: FSM state
// encodings and the default operand width.
`ifndef ADDER_CTRL_DEFS_VH
`define ADDER_CTRL_DEFS_VH

`define ADDER_ST_IDLE       2'd0
`define ADDER_ST_ADD        2'd1
`define ADDER_ST_DONE       2'd2
`define ADDER_DEFAULT_WIDTH 8

`endif

// File: rtl/two_bit_adder_cin.sv
// Stateless 2-bit adder slice with carry in and carry out.
module two_bit_adder_cin (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] z,
    output logic       carry
);

    logic [2:0] total;

    // Full 2-bit sum; the top bit is the slice carry.
    always_comb begin
        total = {1'b0, x} + {1'b0, y} + {2'b00, cin};
        z     = total[1:0];
        carry = total[2];
    end

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit unsigned operands two bits
// per clock, one 2-bit slice per ADD cycle, carrying between slices
// through a register.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             done
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("multi_cycle_adder: WIDTH must be even and at least 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [1:0]       slice_x;
    logic [1:0]       slice_y;
    logic [1:0]       slice_z;
    logic             slice_c;

    // Select the operand bits of the slice currently being processed.
    always_comb begin
        slice_x = op_a[{idx, 1'b0} +: 2];
        slice_y = op_b[{idx, 1'b0} +: 2];
    end

    two_bit_adder_cin u_slice (
        .x     (slice_x),
        .y     (slice_y),
        .cin   (carry_r),
        .z     (slice_z),
        .carry (slice_c)
    );

    // Operand capture on an accepted start; later changes on a/b are ignored.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_IDLE) && start) begin
            op_a <= a;
            op_b <= b;
        end
    end

    // Control FSM, slice counter, running carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        carry_r <= 1'b0;
                        idx     <= '0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum_r[{idx, 1'b0} +: 2] <= slice_z;
                    carry_r                 <= slice_c;
                    if (idx == LAST_IDX) begin
                        // Last slice: publish the final carry and park the
                        // index at 0 explicitly instead of letting it wrap.
                        idx    <= '0;
                        cout_r <= slice_c;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and result outputs decoded from the registered state.
    always_comb begin
        ready     = (state == ST_IDLE);
        done      = (state == ST_DONE);
        sum       = sum_r;
        carry_out = cout_r;
    end

endmodule
